// File: rtl/imem_boot_loader.sv
// Boot loader for the instruction memory: receives a length-prefixed byte image,
// writes it word by word from address 0, then hands the address port to fetch.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  boot_start,
  input  logic [31:0]           fetch_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  output logic                  fetch_stall,
  output logic                  cpu_rst_n,
  output logic                  load_done,
  output logic                  load_error
);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    WRITE,
    RUN,
    ERROR
  } state_t;

  // Header lengths are compared at 17 bits so that N == capacity is accepted.
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  state_t                state, state_next;
  logic [15:0]           len;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [15:0]           hdr_len;
  logic [15:0]           word_cnt_inc;
  logic                  accept;
  logic                  unused_fetch_bits;

  assign hdr_len           = {rx_data, len[7:0]};
  assign word_cnt_inc      = 16'(word_cnt) + 16'd1;
  assign accept            = rx_valid && rx_ready;
  assign unused_fetch_bits = ^{fetch_addr[31:ADDR_WIDTH+2], fetch_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= HDR0;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    rx_ready    = 1'b0;
    mem_we      = 1'b0;
    fetch_stall = 1'b1;
    mem_addr    = word_cnt[ADDR_WIDTH-1:0];
    case (state)
      HDR0: begin
        rx_ready = 1'b1;
        if (rx_valid) state_next = HDR1;
      end
      HDR1: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if (hdr_len == 16'd0)                state_next = RUN;
          else if ({1'b0, hdr_len} > CAPACITY) state_next = ERROR;
          else                                 state_next = DATA;
        end
      end
      DATA: begin
        rx_ready = 1'b1;
        if (rx_valid && byte_cnt == 2'd3) state_next = WRITE;
      end
      WRITE: begin
        mem_we     = 1'b1;
        state_next = (word_cnt_inc == len) ? RUN : DATA;
      end
      RUN: begin
        // Fetch drives the read address directly so reads add no latency.
        fetch_stall = 1'b0;
        mem_addr    = fetch_addr[ADDR_WIDTH+1:2];
        if (boot_start) state_next = HDR0;
      end
      ERROR: ;
      default: state_next = HDR0;
    endcase
  end

  // Status outputs follow the next state so cpu_rst_n rises on the first RUN cycle from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len        <= '0;
      byte_cnt   <= '0;
      word_cnt   <= '0;
      mem_wdata  <= '0;
      cpu_rst_n  <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      cpu_rst_n  <= (state_next == RUN);
      load_done  <= (state_next == RUN);
      load_error <= (state_next == ERROR);
      case (state)
        HDR0: if (accept) len[7:0] <= rx_data;
        HDR1: begin
          if (accept) begin
            len[15:8] <= rx_data;
            byte_cnt  <= '0;
            word_cnt  <= '0;
          end
        end
        DATA: begin
          if (accept) begin
            mem_wdata[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt                          <= byte_cnt + 2'd1;
          end
        end
        WRITE: word_cnt <= word_cnt + (ADDR_WIDTH + 1)'(1);
        RUN: begin
          if (boot_start) begin
            len      <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: a queue of expected memory writes plus
// per-cycle ownership rules, backed by directed literal checks for each scenario.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        boot_start;
  logic [31:0] fetch_addr;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        fetch_stall;
  logic        cpu_rst_n;
  logic        load_done;
  logic        load_error;

  imem_boot_loader #(.ADDR_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .boot_start  (boot_start),
    .fetch_addr  (fetch_addr),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .fetch_stall (fetch_stall),
    .cpu_rst_n   (cpu_rst_n),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expWrites[$];
  wr_t         cmpExp;
  int          checkCount = 0;
  int          passCount  = 0;
  int          writesSeen = 0;
  int          writesBefore;
  logic [7:0]  lastAddr = '0;
  logic [31:0] lastData = '0;
  logic [31:0] word;
  bit          started = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Every memory write must match the next expected word; ownership rules hold every cycle.
  always @(posedge clk) begin
    #1;
    if (started && rst_n) begin
      if (mem_we === 1'b1) begin
        if (expWrites.size() == 0) begin
          checkOutput("unexpectedWrite", {24'd0, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          cmpExp = expWrites.pop_front();
          checkOutput("writeAddr", {24'd0, mem_addr}, {24'd0, cmpExp.addr});
          checkOutput("writeData", mem_wdata, cmpExp.data);
          checkOutput("writeStall", {31'd0, fetch_stall}, 32'd1);
        end
        writesSeen++;
        lastAddr = mem_addr;
        lastData = mem_wdata;
      end
      checkOutput("cpuRstVsStall", {31'd0, cpu_rst_n}, {31'd0, !fetch_stall});
      checkOutput("doneVsStall", {31'd0, load_done}, {31'd0, !fetch_stall});
      if (fetch_stall === 1'b0)
        checkOutput("fetchAddrMux", {24'd0, mem_addr}, {24'd0, fetch_addr[9:2]});
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input bit gaps);
    int  cycles   = 0;
    bit  accepted = 1'b0;
    while (!accepted && cycles < 200) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
      end else begin
        rx_valid = 1'b1;
        rx_data  = b;
      end
      accepted = rx_valid && (rx_ready === 1'b1);
      @(posedge clk);
      #1;
      cycles++;
    end
    rx_valid = 1'b0;
    if (!accepted) checkOutput("byteTimeout", 32'd0, 32'd1);
  endtask

  task automatic sendHeader(input logic [15:0] n, input bit gaps);
    applyStimulus(n[7:0], gaps);
    applyStimulus(n[15:8], gaps);
  endtask

  task automatic sendWord(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) applyStimulus(w[8*k +: 8], gaps);
  endtask

  task automatic waitRun(input int budget);
    int c = 0;
    while (load_done !== 1'b1 && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    checkOutput("runReached", {31'd0, load_done}, 32'd1);
  endtask

  task automatic pulseBootStart();
    @(negedge clk);
    boot_start = 1'b1;
    @(posedge clk);
    #1;
    boot_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = '0;
    boot_start = 1'b0;
    fetch_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstRxReady", {31'd0, rx_ready}, 32'd1);
    checkOutput("rstMemWe", {31'd0, mem_we}, 32'd0);
    checkOutput("rstWdata", mem_wdata, 32'd0);
    checkOutput("rstCpuRst", {31'd0, cpu_rst_n}, 32'd0);
    checkOutput("rstDone", {31'd0, load_done}, 32'd0);
    checkOutput("rstError", {31'd0, load_error}, 32'd0);
    checkOutput("rstStall", {31'd0, fetch_stall}, 32'd1);
    started = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Empty image goes straight to RUN
    writesBefore = writesSeen;
    sendHeader(16'h0000, 1'b0);
    checkOutput("emptyCpuRst", {31'd0, cpu_rst_n}, 32'd1);
    checkOutput("emptyDone", {31'd0, load_done}, 32'd1);
    checkOutput("emptyNoWrites", writesSeen - writesBefore, 32'd0);

    // Two-word image after a reload
    pulseBootStart();
    checkOutput("reloadRxReady", {31'd0, rx_ready}, 32'd1);
    writesBefore = writesSeen;
    expWrites.push_back('{addr: 8'd0, data: 32'h0000_0013});
    expWrites.push_back('{addr: 8'd1, data: 32'h0010_0093});
    sendHeader(16'h0002, 1'b0);
    sendWord(32'h0000_0013, 1'b0);
    sendWord(32'h0010_0093, 1'b0);
    waitRun(20);
    checkOutput("twoWordCount", writesSeen - writesBefore, 32'd2);
    checkOutput("twoWordLastAddr", {24'd0, lastAddr}, 32'd1);
    checkOutput("twoWordLastData", lastData, 32'h0010_0093);

    // Fetch owns the address port in RUN
    @(negedge clk);
    fetch_addr = 32'h0000_0008;
    #1;
    checkOutput("fetchMemAddr", {24'd0, mem_addr}, 32'd2);
    checkOutput("fetchStallRun", {31'd0, fetch_stall}, 32'd0);
    fetch_addr = 32'h0000_03FC;
    #1;
    checkOutput("fetchMemAddrTop", {24'd0, mem_addr}, 32'd255);
    pulseBootStart();
    checkOutput("bootStall", {31'd0, fetch_stall}, 32'd1);
    checkOutput("bootCpuRst", {31'd0, cpu_rst_n}, 32'd0);
    checkOutput("bootRxReady", {31'd0, rx_ready}, 32'd1);

    // Oversized header locks into ERROR until rst_n
    sendHeader(16'h0101, 1'b0);
    checkOutput("errFlag", {31'd0, load_error}, 32'd1);
    checkOutput("errRxReady", {31'd0, rx_ready}, 32'd0);
    checkOutput("errCpuRst", {31'd0, cpu_rst_n}, 32'd0);
    pulseBootStart();
    checkOutput("errSticky", {31'd0, load_error}, 32'd1);
    checkOutput("errStickyRx", {31'd0, rx_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("errCleared", {31'd0, load_error}, 32'd0);
    checkOutput("errClearedRx", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-capacity image with a gappy source
    writesBefore = writesSeen;
    for (int i = 0; i < 256; i++) begin
      word = {8'(i) ^ 8'h5A, ~8'(i), 8'(i), 8'hC3};
      expWrites.push_back('{addr: 8'(i), data: word});
    end
    sendHeader(16'd256, 1'b1);
    for (int i = 0; i < 256; i++) begin
      word = {8'(i) ^ 8'h5A, ~8'(i), 8'(i), 8'hC3};
      sendWord(word, 1'b1);
    end
    waitRun(20);
    checkOutput("fullCount", writesSeen - writesBefore, 32'd256);
    checkOutput("fullLastAddr", {24'd0, lastAddr}, 32'd255);
    checkOutput("fullLastData", lastData, 32'hA5_00_FF_C3);

    // Reset mid-load, then a fresh one-word image
    pulseBootStart();
    expWrites.push_back('{addr: 8'd0, data: 32'h1122_3344});
    sendHeader(16'h0002, 1'b0);
    sendWord(32'h1122_3344, 1'b0);
    applyStimulus(8'h55, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midRstRxReady", {31'd0, rx_ready}, 32'd1);
    checkOutput("midRstWdata", mem_wdata, 32'd0);
    checkOutput("midRstCpuRst", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    writesBefore = writesSeen;
    expWrites.push_back('{addr: 8'd0, data: 32'hEFBE_ADDE});
    sendHeader(16'h0001, 1'b0);
    sendWord(32'hEFBE_ADDE, 1'b0);
    waitRun(20);
    checkOutput("freshCount", writesSeen - writesBefore, 32'd1);
    checkOutput("freshAddr", {24'd0, lastAddr}, 32'd0);
    checkOutput("freshData", lastData, 32'hEFBE_ADDE);

    repeat (3) @(posedge clk);
    #2;
    checkOutput("queueEmpty", expWrites.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
